// File: rtl/riscv_run_ctrl.sv
// Run controller for a small RISC-V core: program load, reset hold, run, and result handshake.
// Optional watchdog enabled by defining RUN_CTRL_WATCHDOG_EN (off by default).
module riscv_run_ctrl #(
    parameter int ADDR_W     = 8,
    parameter int DATA_W     = 32,
    parameter int RST_HOLD   = 4,
    parameter int MAX_CYCLES = 1000
) (
    input  logic              clock,
    input  logic              rst,
    input  logic              ld_valid,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    output logic              ld_ready,
    input  logic              start,
    input  logic              abort,
    input  logic              ack,
    input  logic              finish_flag,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [DATA_W-1:0] imem_wdata,
    output logic              core_rst,
    output logic              busy,
    output logic              done,
    output logic              timeout,
    output logic [31:0]       cycle_count
);

    typedef enum logic [2:0] {IDLE, HOLD, RUN, DONE, TOUT} state_t;

    localparam int HW = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;

    if (RST_HOLD < 1 || MAX_CYCLES < 2) begin : g_param_check
        $error("riscv_run_ctrl: RST_HOLD must be >= 1 and MAX_CYCLES >= 2");
    end

    state_t        state;
    logic [HW-1:0] hold_cnt;
    logic [31:0]   cc_inc;
    logic          ld_take;

    // Saturating so a runaway core without a watchdog never wraps the count.
    assign cc_inc   = (cycle_count == 32'hFFFF_FFFF) ? cycle_count : cycle_count + 32'd1;
    assign ld_ready = (state == IDLE) && !start && !abort;
    assign ld_take  = ld_valid && ld_ready;

`ifdef RUN_CTRL_WATCHDOG_EN
    logic timeout_q;
    assign timeout = timeout_q;
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (!rst) begin
            state       <= IDLE;
            hold_cnt    <= '0;
            core_rst    <= 1'b1;
            imem_we     <= 1'b0;
            imem_addr   <= '0;
            imem_wdata  <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            cycle_count <= '0;
`ifdef RUN_CTRL_WATCHDOG_EN
            timeout_q   <= 1'b0;
`endif
        end else begin
            // A word accepted last cycle still writes even if abort arrives now.
            imem_we <= ld_take;
            if (ld_take) begin
                imem_addr  <= ld_addr;
                imem_wdata <= ld_data;
            end

            if (abort) begin
                state    <= IDLE;
                core_rst <= 1'b1;
                busy     <= 1'b0;
                done     <= 1'b0;
`ifdef RUN_CTRL_WATCHDOG_EN
                timeout_q <= 1'b0;
`endif
            end else begin
                case (state)
                    IDLE, DONE, TOUT: begin
                        if (start) begin
                            state       <= HOLD;
                            hold_cnt    <= HW'(RST_HOLD - 1);
                            core_rst    <= 1'b1;
                            busy        <= 1'b1;
                            done        <= 1'b0;
                            cycle_count <= '0;
`ifdef RUN_CTRL_WATCHDOG_EN
                            timeout_q   <= 1'b0;
`endif
                        end else if (ack) begin
                            state <= IDLE;
                            done  <= 1'b0;
`ifdef RUN_CTRL_WATCHDOG_EN
                            timeout_q <= 1'b0;
`endif
                        end
                    end
                    HOLD: begin
                        if (hold_cnt == '0) begin
                            state    <= RUN;
                            core_rst <= 1'b0;
                        end else begin
                            hold_cnt <= hold_cnt - 1'b1;
                        end
                    end
                    RUN: begin
                        // The finishing cycle is counted, so the count always advances here.
                        cycle_count <= cc_inc;
                        if (finish_flag) begin
                            state    <= DONE;
                            done     <= 1'b1;
                            core_rst <= 1'b1;
                            busy     <= 1'b0;
                        end
`ifdef RUN_CTRL_WATCHDOG_EN
                        else if (cc_inc == 32'(MAX_CYCLES)) begin
                            state     <= TOUT;
                            timeout_q <= 1'b1;
                            core_rst  <= 1'b1;
                            busy      <= 1'b0;
                        end
`endif
                    end
                    default: begin
                        state    <= IDLE;
                        core_rst <= 1'b1;
                        busy     <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
